// File: rtl/cmp_trend_tracker_pkg.sv
// Shared relation encodings and flag decode
// for the comparator trend tracker.
package cmp_trend_tracker_pkg;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_LT   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_GT   = 2'b11
  } rel_e;

  typedef struct packed {
    rel_e rel;
    logic bad;
  } dec_t;

  // flags ordered {agb,aeb,alb}
  function automatic dec_t cmp_decode(
    input logic [2:0] f
  );
    dec_t d;
    d.rel = CMP_NONE;
    d.bad = 1'b0;
    unique case (f)
      3'b001: d.rel = CMP_LT;
      3'b010: d.rel = CMP_EQ;
      3'b100: d.rel = CMP_GT;
      default: d.bad = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmp_trend_tracker_if.sv
// Comparator flag input and tracker
// status output bundle.
interface cmp_trend_tracker_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             alb;
  logic             aeb;
  logic             agb;
  logic [1:0]       state;
  logic             cross_up;
  logic             cross_dn;
  logic [CNT_W-1:0] cross_count;
  logic             err;

  modport master (
    output in_valid, alb, aeb, agb,
    input  state, cross_up, cross_dn,
    input  cross_count, err
  );

  modport slave (
    input  in_valid, alb, aeb, agb,
    output state, cross_up, cross_dn,
    output cross_count, err
  );
endinterface

// File: rtl/cmp_stable_filter.sv
// Run-length qualifier: a relation is accepted
// once seen STABLE_CNT consecutive valid times.
module cmp_stable_filter
  import cmp_trend_tracker_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  rel_e rel_i,
  input  logic illegal_i,
  output logic accept_o,
  output rel_e rel_o
);

  localparam int RW = $clog2(STABLE_CNT + 1);
  localparam logic [RW-1:0] RMAX = RW'(STABLE_CNT);

  if (STABLE_CNT < 1) begin : g_bad_cfg
    $error("STABLE_CNT must be >= 1");
  end

  rel_e          cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;

  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    if (in_valid_i) begin
      if (illegal_i) begin
        cand_d = CMP_NONE;
        run_d  = '0;
      end else if (rel_i == cand_q) begin
        if (run_q != RMAX)
          run_d = run_q + 1'b1;
      end else begin
        cand_d = rel_i;
        run_d  = RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= CMP_NONE;
      run_q  <= '0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end

  // accept looks at the updated count so
  // state moves on the qualifying edge
  assign accept_o = in_valid_i && !illegal_i &&
                    (run_d == RMAX);
  assign rel_o    = rel_i;

endmodule

// File: rtl/cmp_trend_tracker.sv
// Accepted-relation tracker with LT<->GT
// crossing pulses and saturating count.
module cmp_trend_tracker
  import cmp_trend_tracker_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 8
) (
  input logic            clk,
  input logic            rst_n,
  cmp_trend_tracker_if.slave bus
);

  dec_t dec;
  logic acc;
  rel_e acc_rel;

  assign dec = cmp_decode(
    {bus.agb, bus.aeb, bus.alb});

  cmp_stable_filter #(
    .STABLE_CNT(STABLE_CNT)
  ) u_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (bus.in_valid),
    .rel_i      (dec.rel),
    .illegal_i  (dec.bad),
    .accept_o   (acc),
    .rel_o      (acc_rel)
  );

  rel_e             state_q, state_d;
  rel_e             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.in_valid && dec.bad) begin
      err_d = 1'b1;
    end else if (acc && acc_rel != state_q) begin
      state_d = acc_rel;
      // last_dir skips EQ, so LT->EQ->GT crosses
      up_d = (acc_rel == CMP_GT) &&
             (last_q == CMP_LT);
      dn_d = (acc_rel == CMP_LT) &&
             (last_q == CMP_GT);
      if ((up_d || dn_d) && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
      if (acc_rel == CMP_LT ||
          acc_rel == CMP_GT)
        last_d = acc_rel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CMP_NONE;
      last_q  <= CMP_NONE;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.cross_up    = up_q;
  assign bus.cross_dn    = dn_q;
  assign bus.cross_count = cnt_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_cmp_trend_tracker.sv
// Scoreboard bench: two tracker configs
// driven in lockstep against a model.
module tb_cmp_trend_tracker;

  localparam logic [2:0] F_LT = 3'b001;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_Z  = 3'b000;
  localparam logic [2:0] F_X  = 3'b101;

  typedef struct {
    int cand;
    int run;
    int st;
    int last;
    int cnt;
  } mdl_t;

  typedef struct {
    int st;
    int up;
    int dn;
    int cnt;
    int err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  mdl_t m0, m1;
  exp_t q0[$];
  exp_t q1[$];

  cmp_trend_tracker_if #(.CNT_W(8)) if0();
  cmp_trend_tracker_if #(.CNT_W(2)) if1();

  cmp_trend_tracker #(
    .STABLE_CNT(3), .CNT_W(8)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  cmp_trend_tracker #(
    .STABLE_CNT(1), .CNT_W(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic mdl_clr(output mdl_t m);
    m.cand = 0;
    m.run  = 0;
    m.st   = 0;
    m.last = 0;
    m.cnt  = 0;
  endtask

  task automatic mdl_step(
    input  int       sc,
    input  int       maxc,
    inout  mdl_t     m,
    input  bit       v,
    input  bit [2:0] f,
    output exp_t     e
  );
    int r;
    e.up  = 0;
    e.dn  = 0;
    e.err = 0;
    if (v) begin
      if (f == 3'b001) r = 1;
      else if (f == 3'b010) r = 2;
      else if (f == 3'b100) r = 3;
      else r = 0;
      if (r == 0) begin
        e.err  = 1;
        m.cand = 0;
        m.run  = 0;
      end else begin
        if (r == m.cand) begin
          if (m.run < sc) m.run++;
        end else begin
          m.cand = r;
          m.run  = 1;
        end
        if (m.run == sc && r != m.st) begin
          if (r == 3 && m.last == 1) e.up = 1;
          if (r == 1 && m.last == 3) e.dn = 1;
          if ((e.up || e.dn) && m.cnt < maxc)
            m.cnt++;
          m.st = r;
          if (r == 1 || r == 3) m.last = r;
        end
      end
    end
    e.st  = m.st;
    e.cnt = m.cnt;
  endtask

  task automatic cmp_out(
    input string       tag,
    input exp_t        e,
    input logic [1:0]  st,
    input logic        up,
    input logic        dn,
    input logic [31:0] cnt,
    input logic        er
  );
    check({tag, ".state"}, 32'(st), e.st);
    check({tag, ".up"}, 32'(up), e.up);
    check({tag, ".dn"}, 32'(dn), e.dn);
    check({tag, ".cnt"}, cnt, e.cnt);
    check({tag, ".err"}, 32'(er), e.err);
  endtask

  task automatic step(
    input bit       v,
    input bit [2:0] f
  );
    exp_t e0, e1;
    @(negedge clk);
    if0.in_valid = v;
    if0.agb = f[2];
    if0.aeb = f[1];
    if0.alb = f[0];
    if1.in_valid = v;
    if1.agb = f[2];
    if1.aeb = f[1];
    if1.alb = f[0];
    mdl_step(3, 255, m0, v, f, e0);
    mdl_step(1, 3, m1, v, f, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      cmp_out("u0", e0, if0.state,
              if0.cross_up, if0.cross_dn,
              32'(if0.cross_count), if0.err);
      cmp_out("u1", e1, if1.state,
              if1.cross_up, if1.cross_dn,
              32'(if1.cross_count), if1.err);
    end
  endtask

  task automatic rep(
    input int       n,
    input bit [2:0] f
  );
    for (int i = 0; i < n; i++) step(1, f);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, ".s0"}, 32'(if0.state), 0);
    check({tag, ".u0"}, 32'(if0.cross_up), 0);
    check({tag, ".d0"}, 32'(if0.cross_dn), 0);
    check({tag, ".c0"},
          32'(if0.cross_count), 0);
    check({tag, ".e0"}, 32'(if0.err), 0);
    check({tag, ".s1"}, 32'(if1.state), 0);
    check({tag, ".c1"},
          32'(if1.cross_count), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    mdl_clr(m0);
    mdl_clr(m1);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mdl_clr(m0);
    mdl_clr(m1);
    if0.in_valid = 1'b0;
    if0.alb = 1'b0;
    if0.aeb = 1'b0;
    if0.agb = 1'b0;
    if1.in_valid = 1'b0;
    if1.alb = 1'b0;
    if1.aeb = 1'b0;
    if1.agb = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, F_Z);
    chk_zero("post_rst");

    // LT accepted, then a broken GT run
    rep(2, F_LT);
    check("t2_lt2", 32'(if0.state), 0);
    step(1, F_LT);
    check("t2_lt3", 32'(if0.state), 1);
    rep(2, F_GT);
    step(1, F_LT);
    rep(2, F_GT);
    check("t2_gt2", 32'(if0.state), 1);
    step(1, F_GT);
    check("t2_gt", 32'(if0.state), 3);
    check("t2_up", 32'(if0.cross_up), 1);
    check("t2_cnt",
          32'(if0.cross_count), 1);
    step(0, F_Z);
    check("t2_up_off",
          32'(if0.cross_up), 0);

    // GT -> EQ -> LT down-crossing
    rep(3, F_EQ);
    check("t3_eq", 32'(if0.state), 2);
    check("t3_eq_dn",
          32'(if0.cross_dn), 0);
    rep(3, F_LT);
    check("t3_lt", 32'(if0.state), 1);
    check("t3_dn", 32'(if0.cross_dn), 1);
    check("t3_cnt",
          32'(if0.cross_count), 2);

    // illegal flags break an LT run
    rep(3, F_EQ);
    rep(2, F_LT);
    step(1, F_Z);
    check("t4_err1", 32'(if0.err), 1);
    step(1, F_X);
    check("t4_err2", 32'(if0.err), 1);
    check("t4_hold", 32'(if0.state), 2);
    rep(2, F_LT);
    check("t4_lt2", 32'(if0.state), 2);
    step(1, F_LT);
    check("t4_lt3", 32'(if0.state), 1);

    // valid gaps keep the run alive
    step(1, F_GT);
    step(0, F_Z);
    step(0, F_Z);
    step(1, F_GT);
    step(0, F_Z);
    check("t5_gap", 32'(if0.state), 1);
    step(1, F_GT);
    check("t5_gt", 32'(if0.state), 3);
    check("t5_up", 32'(if0.cross_up), 1);
    rep(3, F_LT);
    rep(2, F_GT);
    do_reset("t5_rst");
    rep(2, F_GT);
    check("t5_re2", 32'(if0.state), 0);
    step(1, F_GT);
    check("t5_re3", 32'(if0.state), 3);
    check("t5_noup",
          32'(if0.cross_up), 0);

    // narrow counter saturation on u1
    do_reset("t6_rst");
    step(1, F_LT);
    check("t6_lt", 32'(if1.state), 1);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        step(1, F_GT);
        check("t6_up", 32'(if1.cross_up), 1);
      end else begin
        step(1, F_LT);
        check("t6_dn", 32'(if1.cross_dn), 1);
      end
      check("t6_cnt", 32'(if1.cross_count),
            (i < 3) ? i + 1 : 3);
    end
    step(0, F_Z);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
